// File: rtl/psum_acc_sequencer_if.sv
// ---------------------------------------------------------------------------
// psum_acc_sequencer_if
//   Signal bundle between the partial-sum accumulation sequencer and its
//   surroundings: the PMEM read port, the SFP accumulate controls and the
//   start/busy/done run control.
//
//   Run-control handshake: start is a single-cycle request that is honoured
//   only while busy is low; a start seen while busy is high is dropped, not
//   queued. busy rises on the first CLR cycle and falls the cycle after the
//   one-cycle done pulse. There is no ready signal.
//
//   master : the sequencer (drives everything except start)
//   slave  : the controller/memory side (drives start)
// ---------------------------------------------------------------------------
interface psum_acc_sequencer_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        CEN_pmem;
    logic        WEN_pmem;
    logic [10:0] A_pmem;
    logic        acc;
    logic        acc_clr;
    logic        out_valid;
    logic [3:0]  onij_idx;

    modport master (
        input  start,
        output busy, done, CEN_pmem, WEN_pmem, A_pmem,
        output acc, acc_clr, out_valid, onij_idx
    );

    modport slave (
        output start,
        input  busy, done, CEN_pmem, WEN_pmem, A_pmem,
        input  acc, acc_clr, out_valid, onij_idx
    );
endinterface

// File: rtl/psum_acc_sequencer.sv
// ---------------------------------------------------------------------------
// psum_acc_sequencer
//   Walks the partial-sum memory for every output pixel of a pass. For each
//   output pixel (onij) it clears the SFP accumulator, reads the len_kij
//   partial sums that contribute to it (one per kernel position), lets the
//   accumulator absorb the last read, then flags the finished sum.
//
//   Ports:
//     clk        clock, rising edge
//     reset      synchronous active-high reset
//     bus        psum_acc_sequencer_if.master (start/busy/done, PMEM port,
//                acc/acc_clr, out_valid, onij_idx)
//     state_dbg  current FSM state encoding
//
//   Every output is a flop: the next-state logic computes the following
//   cycle's state and counters, and the outputs are registered from those.
// ---------------------------------------------------------------------------
module psum_acc_sequencer #(
    parameter int len_kij        = 9,
    parameter int len_kij_dim_1  = 3,
    parameter int len_onij       = 16,
    parameter int len_onij_dim_1 = 4,
    parameter int len_nij        = 36,
    parameter int len_nij_dim_1  = 6,
    parameter int base_addr      = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    psum_acc_sequencer_if.master   bus,
    output logic [2:0]             state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        FLUSH = 3'd4,
        VALID = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam int CW = 8;

    state_t        state, state_n;
    logic [CW-1:0] j, j_n;
    logic [CW-1:0] krow, krow_n, kcol, kcol_n;
    logic [CW-1:0] orow, orow_n, ocol, ocol_n;
    logic [3:0]    onij, onij_n;
    logic [10:0]   addr_n;

    always_comb begin
        state_n = state;
        j_n     = j;
        krow_n  = krow;
        kcol_n  = kcol;
        orow_n  = orow;
        ocol_n  = ocol;
        onij_n  = onij;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = CLR;
                    j_n     = '0;
                    krow_n  = '0;
                    kcol_n  = '0;
                    orow_n  = '0;
                    ocol_n  = '0;
                    onij_n  = '0;
                end
            end
            CLR: begin
                state_n = READ;
                j_n     = '0;
                krow_n  = '0;
                kcol_n  = '0;
            end
            READ: begin
                if (j == CW'(len_kij - 1)) begin
                    state_n = DRAIN;
                end else begin
                    j_n = j + 1'b1;
                    // Kernel row/column follow j as a wrap counter pair.
                    if (kcol == CW'(len_kij_dim_1 - 1)) begin
                        kcol_n = '0;
                        krow_n = krow + 1'b1;
                    end else begin
                        kcol_n = kcol + 1'b1;
                    end
                end
            end
            DRAIN: state_n = FLUSH;
            FLUSH: state_n = VALID;
            VALID: begin
                if (onij == 4'(len_onij - 1)) begin
                    state_n = DONE;
                end else begin
                    state_n = CLR;
                    onij_n  = onij + 1'b1;
                    if (ocol == CW'(len_onij_dim_1 - 1)) begin
                        ocol_n = '0;
                        orow_n = orow + 1'b1;
                    end else begin
                        ocol_n = ocol + 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                onij_n  = '0;
                orow_n  = '0;
                ocol_n  = '0;
            end
            default: state_n = IDLE;
        endcase

        // Address of the next cycle's read; the sum wraps at 11 bits.
        addr_n = 11'(32'(base_addr)
                   + 32'(j_n)    * 32'(len_nij)
                   + 32'(orow_n) * 32'(len_nij_dim_1) + 32'(ocol_n)
                   + 32'(krow_n) * 32'(len_nij_dim_1) + 32'(kcol_n));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            j             <= '0;
            krow          <= '0;
            kcol          <= '0;
            orow          <= '0;
            ocol          <= '0;
            onij          <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.CEN_pmem  <= 1'b1;
            bus.WEN_pmem  <= 1'b1;
            bus.A_pmem    <= '0;
            bus.acc       <= 1'b0;
            bus.acc_clr   <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            state         <= state_n;
            j             <= j_n;
            krow          <= krow_n;
            kcol          <= kcol_n;
            orow          <= orow_n;
            ocol          <= ocol_n;
            onij          <= onij_n;
            bus.busy      <= (state_n != IDLE);
            bus.done      <= (state_n == DONE);
            bus.CEN_pmem  <= (state_n != READ);
            bus.WEN_pmem  <= 1'b1;
            bus.A_pmem    <= (state_n == READ) ? addr_n : '0;
            // acc trails the reads by one cycle: off for the first read,
            // on for the rest and for DRAIN, when the last datum returns.
            bus.acc       <= ((state_n == READ) && (j_n != '0)) || (state_n == DRAIN);
            bus.acc_clr   <= (state_n == CLR);
            bus.out_valid <= (state_n == VALID);
        end
    end

    assign bus.onij_idx = onij;
    assign state_dbg    = state;

endmodule

// File: tb/tb_psum_acc_sequencer.sv
module tb_psum_acc_sequencer;

    localparam int LEN_KIJ  = 9;
    localparam int LEN_ONIJ = 16;

    logic       clk;
    logic       reset;
    logic [2:0] state_dbg;

    psum_acc_sequencer_if bus ();

    psum_acc_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [10:0] exp_q[$];
    logic [3:0]  onij_q[$];

    int err_cnt = 0;
    int chk_cnt = 0;

    int busy_cnt, clr_cnt, valid_cnt, acc_run;
    logic last_prev;

    int tbl0  [9] = '{0, 37, 74, 114, 151, 188, 228, 265, 302};
    int tbl5  [9] = '{7, 44, 81, 121, 158, 195, 235, 272, 309};
    int tbl15 [9] = '{21, 58, 95, 135, 172, 209, 249, 286, 323};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference addresses computed directly from the pixel geometry.
    task automatic push_pass();
        for (int o = 0; o < LEN_ONIJ; o++) begin
            for (int k = 0; k < LEN_KIJ; k++) begin
                exp_q.push_back(11'(k * 36 + (o / 4) * 6 + (o % 4) + (k / 3) * 6 + (k % 3)));
            end
            onij_q.push_back(4'(o));
        end
    endtask

    task automatic clear_stats();
        busy_cnt  = 0;
        clr_cnt   = 0;
        valid_cnt = 0;
        acc_run   = 0;
    endtask

    // ---------------- monitor ----------------
    initial last_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.busy) busy_cnt++;
        if (bus.acc_clr) begin
            clr_cnt++;
            acc_run = 0;
        end
        if (bus.acc) acc_run++;
        if (!bus.CEN_pmem) begin
            if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
            else check("rd_addr_sb", 32'(bus.A_pmem), 32'(exp_q.pop_front()));
            check("rd_wen", bus.WEN_pmem, 1);
        end
        if (bus.out_valid) begin
            valid_cnt++;
            if (onij_q.size() == 0) check("valid_unexpected", 1, 0);
            else check("valid_onij_sb", bus.onij_idx, onij_q.pop_front());
            check("acc_len", acc_run, LEN_KIJ);
        end
        if (bus.done || last_prev) check("done_timing", bus.done, last_prev);
        last_prev = bus.out_valid && (bus.onij_idx == 4'(LEN_ONIJ - 1));
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cen"},   bus.CEN_pmem, 1);
        check({tag, "_wen"},   bus.WEN_pmem, 1);
        check({tag, "_addr"},  bus.A_pmem, 0);
        check({tag, "_acc"},   bus.acc, 0);
        check({tag, "_clr"},   bus.acc_clr, 0);
        check({tag, "_valid"}, bus.out_valid, 0);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_done"},  bus.done, 0);
        check({tag, "_onij"},  bus.onij_idx, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    // Finds the first read of the given output pixel, then checks the whole
    // read/drain/flush/valid window of it cycle by cycle.
    task automatic check_onij_reads(input int onij, input int tbl [9]);
        int n;
        logic found;
        n = 0;
        found = 1'b0;
        while (!found && n < 400) begin
            @(negedge clk);
            n++;
            if (!bus.CEN_pmem && !bus.acc && bus.onij_idx == 4'(onij)) found = 1'b1;
        end
        if (!found) begin
            check("wait_first_read", 0, 1);
        end else begin
            for (int k = 0; k < LEN_KIJ; k++) begin
                if (k > 0) @(negedge clk);
                check("rd_addr", bus.A_pmem, tbl[k]);
                check("rd_cen", bus.CEN_pmem, 0);
                check("rd_acc", bus.acc, (k != 0));
                check("rd_onij", bus.onij_idx, onij);
            end
            @(negedge clk);
            check("drain_acc", bus.acc, 1);
            check("drain_cen", bus.CEN_pmem, 1);
            @(negedge clk);
            check("flush_acc", bus.acc, 0);
            check("flush_valid", bus.out_valid, 0);
            @(negedge clk);
            check("valid_flag", bus.out_valid, 1);
            check("valid_onij", bus.onij_idx, onij);
        end
    endtask

    task automatic wait_done_and_check();
        int n;
        n = 0;
        while (!bus.done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", bus.done, 1);
        check("done_busy", bus.busy, 1);
        @(negedge clk);
        check("post_done_busy", bus.busy, 0);
        check("post_done_done", bus.done, 0);
        check("busy_cycles", busy_cnt, 209);
        check("valid_pulses", valid_cnt, 16);
        check("clr_pulses", clr_cnt, 16);
        check("sb_addr_empty", exp_q.size(), 0);
        check("sb_onij_empty", onij_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic found;
        reset     = 1'b1;
        bus.start = 1'b0;
        clear_stats();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst");

        // Full pass with detailed checks on onij 0, 5 and 15.
        repeat ($urandom_range(1, 5)) @(posedge clk);
        clear_stats();
        push_pass();
        pulse_start();
        @(negedge clk);
        check("clr_flag", bus.acc_clr, 1);
        check("clr_busy", bus.busy, 1);
        check("clr_onij", bus.onij_idx, 0);
        check("clr_cen", bus.CEN_pmem, 1);
        check_onij_reads(0, tbl0);
        check_onij_reads(5, tbl5);
        check_onij_reads(15, tbl15);
        wait_done_and_check();

        // Start pulsed while reading onij 3 must be ignored.
        repeat ($urandom_range(1, 5)) @(posedge clk);
        clear_stats();
        push_pass();
        pulse_start();
        n = 0;
        found = 1'b0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (!bus.CEN_pmem && bus.acc && bus.onij_idx == 4'd3) found = 1'b1;
        end
        check("wait_onij3_read", found, 1);
        pulse_start();
        wait_done_and_check();

        // Reset in the middle of onij 2, at read j=4 (address 153).
        repeat ($urandom_range(1, 5)) @(posedge clk);
        clear_stats();
        push_pass();
        pulse_start();
        n = 0;
        found = 1'b0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (!bus.CEN_pmem && bus.onij_idx == 4'd2 && bus.A_pmem == 11'd153) found = 1'b1;
        end
        check("wait_onij2_j4", found, 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        onij_q.delete();
        @(negedge clk);
        check_reset_outputs("midrst");

        repeat ($urandom_range(1, 5)) @(posedge clk);
        clear_stats();
        push_pass();
        pulse_start();
        check_onij_reads(0, tbl0);
        wait_done_and_check();

        // Start and reset together in IDLE: reset wins.
        repeat ($urandom_range(1, 5)) @(posedge clk);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_start");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_start_busy", bus.busy, 0);
            check("rst_start_state", state_dbg, 0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/psum_acc_sequencer.md
PSUM_ACC_SEQUENCER -- requirements
Module: psum_acc_sequencer

Interface
REQ-001 SHALL have parameter len_kij, default 9, meaning kernel positions per output pixel.
REQ-002 SHALL have parameter len_kij_dim_1, default 3, meaning kernel row width.
REQ-003 SHALL have parameter len_onij, default 16, meaning output pixels per pass.
REQ-004 SHALL have parameter len_onij_dim_1, default 4, meaning output row width.
REQ-005 SHALL have parameter len_nij, default 36, meaning input pixels, which is also the PMEM stride per kij.
REQ-006 SHALL have parameter len_nij_dim_1, default 6, meaning input row width.
REQ-007 SHALL have parameter base_addr, default 0, meaning the PMEM address of kij 0, nij 0.
REQ-008 SHALL use one clock and a synchronous, active-high reset: clk  input  1  clock; all state updates on the rising edge.
REQ-009 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-010 SHALL have port start  input  1  one-cycle request to run a full accumulation pass.
REQ-011 SHALL have port busy  output  1  high from the first CLR cycle through the DONE cycle.
REQ-012 SHALL have port done  output  1  one-cycle pulse at the end of a pass.
REQ-013 SHALL have port CEN_pmem  output  1  PMEM chip enable, active low.
REQ-014 SHALL have port WEN_pmem  output  1  PMEM write enable, active low; this block only reads, so it is held at 1.
REQ-015 SHALL have port A_pmem  output  11  PMEM read address.
REQ-016 SHALL have port acc  output  1  SFP accumulate enable.
REQ-017 SHALL have port acc_clr  output  1  SFP accumulator clear.
REQ-018 SHALL have port out_valid  output  1  sfp_out holds the final sum for onij_idx.
REQ-019 SHALL have port onij_idx  output  4  index of the output pixel currently being accumulated.

Function
REQ-020 SHALL drive every output from registers, with no combinational path from input to output.
REQ-021 SHALL implement states IDLE, CLR, READ, DRAIN, FLUSH, VALID and DONE.
REQ-022 SHALL accept start only in IDLE and ignore it in every other state.
REQ-023 SHALL go to CLR on the edge after start is sampled, with acc_clr=1 for exactly that cycle.
REQ-024 SHALL transition IDLE->CLR->READ (len_kij cycles)->DRAIN->FLUSH->VALID.
REQ-025 SHALL go from VALID to CLR for the next onij, or to DONE after onij = len_onij-1.
REQ-026 SHALL go from DONE to IDLE after 1 cycle.
REQ-027 SHALL hold, in READ cycle j (0..len_kij-1), CEN_pmem=0, WEN_pmem=1 and A_pmem = base_addr + j*len_nij + (orow*len_nij_dim_1+ocol) + (krow*len_nij_dim_1+kcol).
REQ-028 SHALL derive orow/ocol from onij and krow/kcol from j using wrap counters (row/column), not dividers.
REQ-029 SHALL set acc=0 on READ j=0, acc=1 on READ j>=1, acc=1 in DRAIN and acc=0 in FLUSH, giving acc exactly len_kij cycles, one cycle behind the reads to match the SRAM read latency.
REQ-030 SHALL hold CEN_pmem=1 in all states other than READ.
REQ-031 SHALL assert out_valid only in VALID.
REQ-032 SHALL keep onij_idx equal to the current onij from CLR through VALID.
REQ-033 SHALL make the address add modulo 2^11; with default parameters the maximum address is 323, so no wrap occurs.
REQ-034 SHALL take 13 cycles per onij and 16*13 = 208 busy cycles for CLR..VALID, plus 1 DONE cycle.
REQ-035 SHALL assert done in DONE together with busy=1, then go to busy=0 the next cycle.

Reset
REQ-036 SHALL, on a reset sample in any state including mid-READ, enter IDLE on that edge.
REQ-037 SHALL, after reset, output CEN_pmem=1, WEN_pmem=1, A_pmem=0, acc=0, acc_clr=0, out_valid=0, busy=0, done=0, onij_idx=0.
REQ-038 SHALL clear all counters on reset, so the next start begins at onij 0.
REQ-039 SHALL give reset priority over start when both are sampled high.

Verification
REQ-040 SHALL be verified for onij 0: reset, then start -> CLR, then A_pmem = 0,37,74,114,151,188,228,265,302 with CEN_pmem=0, and acc pattern 0,1,1,1,1,1,1,1,1,1(DRAIN),0(FLUSH).
REQ-041 SHALL be verified for onij 5 (offset 7): A_pmem = 7,44,81,121,158,195,235,272,309; out_valid with onij_idx=5.
REQ-042 SHALL be verified for onij 15: first A_pmem=21 and last A_pmem=323; done 1 cycle after the 16th out_valid; busy high for 209 cycles; 16 out_valid pulses and 16 acc_clr pulses.
REQ-043 SHALL be verified for start pulsed during READ of onij 3: no restart, and the address sequence is unchanged.
REQ-044 SHALL be verified for reset asserted at READ j=4 of onij 2: next cycle all outputs at reset values; a new start yields the onij 0 sequence.
REQ-045 SHALL be verified for start and reset high together in IDLE: the block stays IDLE, busy=0.
